// File: rtl/am_mod_tx.sv
// AM transmitter: audio FIFO, sample tick, envelope pipeline, NCO carrier and 1-bit sigma-delta RF drive.
// Define AM_MOD_TX_LINEAR_INTERP_EN to ramp the envelope linearly between samples instead of stepping.
module am_mod_tx #(
    parameter int PHASE_W     = 40,
    parameter int INTERP_LOG2 = 10,
    parameter int FIFO_LOG2   = 2
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [PHASE_W-1:0]       phase_inc,
    input  logic                     enable,
    input  logic signed [15:0]       audio_in,
    input  logic                     audio_valid,
    output logic                     audio_ready,
    input  logic [7:0]               mod_depth,
    output logic                     rf_out,
    output logic [15:0]              env_out,
    output logic                     underrun
);
    localparam int DEPTH = 1 << FIFO_LOG2;

    function automatic logic [15:0] sat_u16(input logic signed [24:0] v);
        if (v < 0)
            return 16'd0;
        if (v > 25'sd65535)
            return 16'hFFFF;
        return v[15:0];
    endfunction

    logic signed [15:0]     fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_LOG2:0]     count_q, count_d;
    logic                   live_q;
    logic                   full, empty, wr_en, rd_en, tick;
    logic [INTERP_LOG2-1:0] tick_cnt_q, tick_cnt_d;
    logic                   underrun_q, underrun_d;
    logic signed [15:0]     held_q, held_d;
    logic signed [17:0]     samp;
    logic signed [24:0]     samp_x, depth_x, prod_d, prod_p0_q;
    logic [15:0]            env_d, env_p1_q;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [16:0]            sd_sum;
    logic [15:0]            sd_acc_q, sd_acc_d;
    logic                   sd_bit_q, sd_bit_d;
    logic                   rf_q, rf_d;

    // live_q keeps audio_ready low while reset is held and releases it on the first free clock
    assign full        = count_q[FIFO_LOG2];
    assign empty       = (count_q == '0);
    assign audio_ready = live_q & ~full;
    assign wr_en       = audio_valid & audio_ready;
    assign tick        = enable & (&tick_cnt_q);
    assign rd_en       = tick & ~empty;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en)
            count_d = count_q + 1'b1;
        else if (!wr_en && rd_en)
            count_d = count_q - 1'b1;
        tick_cnt_d = enable ? tick_cnt_q + 1'b1 : '0;
        underrun_d = enable & (underrun_q | (tick & empty));
        held_d     = rd_en ? fifo_mem[rd_ptr_q] : held_q;
        phase_d    = enable ? phase_q + phase_inc : '0;
        sd_sum     = {1'b0, sd_acc_q} + {1'b0, env_p1_q};
        sd_acc_d   = enable ? sd_sum[15:0] : '0;
        sd_bit_d   = enable & sd_sum[16];
        rf_d       = enable & phase_q[PHASE_W-1] & sd_bit_q;
    end

`ifdef AM_MOD_TX_LINEAR_INTERP_EN
    logic signed [17:0] interp_q, interp_d, delta_q, delta_d;
    logic signed [16:0] diff;

    // Each tick snaps to the sample just reached and ramps towards the one being popped
    always_comb begin
        diff     = 17'(fifo_mem[rd_ptr_q]) - 17'(held_q);
        interp_d = interp_q;
        delta_d  = delta_q;
        if (tick) begin
            interp_d = 18'(held_q);
            delta_d  = rd_en ? 18'(diff >>> INTERP_LOG2) : '0;
        end else if (enable) begin
            interp_d = interp_q + delta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            interp_q <= '0;
            delta_q  <= '0;
        end else begin
            interp_q <= interp_d;
            delta_q  <= delta_d;
        end
    end

    assign samp = interp_q;
`else
    assign samp = 18'(held_q);
`endif

    assign samp_x  = 25'(samp);
    assign depth_x = $signed({17'd0, mod_depth});
    assign prod_d  = samp_x * depth_x;
    assign env_d   = sat_u16((prod_p0_q >>> 8) + 25'sd32768);

    always_ff @(posedge clk) begin
        if (RST) begin
            live_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tick_cnt_q <= '0;
            underrun_q <= 1'b0;
            held_q     <= '0;
            prod_p0_q  <= '0;
            env_p1_q   <= 16'h8000;
            phase_q    <= '0;
            sd_acc_q   <= '0;
            sd_bit_q   <= 1'b0;
            rf_q       <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            tick_cnt_q <= tick_cnt_d;
            underrun_q <= underrun_d;
            held_q     <= held_d;
            // stage p0: modulation product; stage p1: offset and saturate
            prod_p0_q  <= prod_d;
            env_p1_q   <= env_d;
            phase_q    <= phase_d;
            sd_acc_q   <= sd_acc_d;
            sd_bit_q   <= sd_bit_d;
            rf_q       <= rf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !RST)
            fifo_mem[wr_ptr_q] <= audio_in;
    end

    assign rf_out   = rf_q;
    assign env_out  = env_p1_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_am_mod_tx.sv
// Directed bench for am_mod_tx: vector table for the envelope plus hand-written FIFO/tick/enable sequences.
module tb_am_mod_tx;
    logic               clk = 1'b0;
    logic               RST;
    logic [39:0]        phase_inc;
    logic               enable;
    logic signed [15:0] audio_in;
    logic               audio_valid;
    logic               audio_ready;
    logic [7:0]         mod_depth;
    logic               rf_out;
    logic [15:0]        env_out;
    logic               underrun;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rf_ones [4];
    logic flag;
    int   total;
    logic [15:0] prev_env;

    typedef struct packed {
        logic signed [15:0] sample;
        logic [7:0]         depth;
        logic [15:0]        env;
    } vec_t;
    vec_t vecs [9];
    logic [15:0] drain_exp [4];

    always #5 clk = ~clk;

    am_mod_tx dut (
        .clk(clk), .RST(RST), .phase_inc(phase_inc), .enable(enable),
        .audio_in(audio_in), .audio_valid(audio_valid), .audio_ready(audio_ready),
        .mod_depth(mod_depth), .rf_out(rf_out), .env_out(env_out), .underrun(underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic push(input logic signed [15:0] s);
        audio_in    = s;
        audio_valid = 1'b1;
        step();
        audio_valid = 1'b0;
    endtask

    task automatic start();
        enable = 1'b1;
        cyc    = 0;
    endtask

    task automatic do_reset();
        RST         = 1'b1;
        enable      = 1'b0;
        audio_valid = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic count_rf(input int n);
        for (int k = 0; k < 4; k++) rf_ones[k] = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (rf_out) rf_ones[cyc % 4]++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{sample: 16'sd32767,  depth: 8'd255, env: 16'd65407};
        vecs[1] = '{sample: 16'sh8000,   depth: 8'd255, env: 16'd128};
        vecs[2] = '{sample: 16'sd12345,  depth: 8'd0,   env: 16'd32768};
        vecs[3] = '{sample: 16'sd1000,   depth: 8'd255, env: 16'd33764};
        vecs[4] = '{sample: -16'sd2000,  depth: 8'd255, env: 16'd30775};
        vecs[5] = '{sample: -16'sd1,     depth: 8'd255, env: 16'd32767};
        vecs[6] = '{sample: 16'sd1000,   depth: 8'd128, env: 16'd33268};
        vecs[7] = '{sample: 16'sd32767,  depth: 8'd128, env: 16'd49151};
        vecs[8] = '{sample: 16'sh8000,   depth: 8'd1,   env: 16'd32640};
        drain_exp[0] = 16'd33764;
        drain_exp[1] = 16'd30775;
        drain_exp[2] = 16'd65407;
        drain_exp[3] = 16'd128;

        RST = 1'b1; enable = 1'b0; audio_valid = 1'b0; audio_in = '0;
        mod_depth = 8'd255; phase_inc = 40'd1 << 38;

        // Reset state
        step();
        step();
        check("rst_ready", audio_ready, 0);
        check("rst_rf", rf_out, 0);
        check("rst_env", env_out, 16'h8000);
        check("rst_underrun", underrun, 0);
        RST = 1'b0;
        step();
        check("ready_after_rst", audio_ready, 1);

        // Idle carrier with an empty FIFO
        start();
        run_to(1023);
        check("underrun_before_tick", underrun, 0);
        run_to(1024);
        check("underrun_at_tick", underrun, 1);
        check("env_idle", env_out, 16'h8000);
        run_to(1100);
        count_rf(64);
        total = rf_ones[0] + rf_ones[1] + rf_ones[2] + rf_ones[3];
        check("rf_half_density", total, 16);

`ifndef AM_MOD_TX_LINEAR_INTERP_EN
        // Fill to full, refuse a fifth write, then drain in order
        do_reset();
        mod_depth = 8'd255;
        push(16'sd1000);
        push(-16'sd2000);
        push(16'sd32767);
        push(16'sh8000);
        check("full_not_ready", audio_ready, 0);
        push(16'sd7777);
        check("fifth_refused", audio_ready, 0);
        start();
        run_to(1024);
        check("ready_after_pop", audio_ready, 1);
        check("no_underrun_first", underrun, 0);
        for (int k = 0; k < 4; k++) begin
            run_to(1024 * (k + 1) + 1);
            check("drain_hold", env_out, (k == 0) ? 32'd32768 : 32'(drain_exp[k-1]));
            run_to(1024 * (k + 1) + 2);
            check("drain_value", env_out, 32'(drain_exp[k]));
        end
        run_to(5119);
        check("underrun_after_four", underrun, 0);
        run_to(5120);
        check("underrun_fifth_tick", underrun, 1);
        run_to(5122);
        check("no_fifth_sample", env_out, 128);

        // Envelope vector table, one sample per tick
        do_reset();
        start();
        for (int i = 0; i < 9; i++) begin
            run_to(1024 * i + 3);
            mod_depth = vecs[i].depth;
            push(vecs[i].sample);
            run_to(1024 * (i + 1) + 2);
            check("env_vector", env_out, 32'(vecs[i].env));
        end
        check("table_no_underrun", underrun, 0);

        // Full-scale envelope gives a carrier-shaped 1,1,0,0 pattern
        do_reset();
        mod_depth = 8'd255;
        push(16'sd32767);
        start();
        run_to(1100);
        check("env_full_scale", env_out, 65407);
        count_rf(64);
        flag = 1'b0;
        for (int k = 0; k < 4; k++)
            if (rf_ones[k] >= 15 && rf_ones[(k+1)%4] >= 15 && rf_ones[(k+2)%4] == 0 && rf_ones[(k+3)%4] == 0)
                flag = 1'b1;
        check("rf_pattern_1100", flag, 1);

        // Enable drop mid-sample and restart
        do_reset();
        mod_depth = 8'd255;
        push(16'sd1000);
        start();
        run_to(2048);
        check("underrun_set", underrun, 1);
        push(-16'sd2000);
        run_to(2436);
        count_rf(64);
        total = rf_ones[0] + rf_ones[1] + rf_ones[2] + rf_ones[3];
        check("rf_active", (total >= 8) ? 1 : 0, 1);
        enable = 1'b0;
        step();
        check("rf_off_on_disable", rf_out, 0);
        check("underrun_cleared", underrun, 0);
        repeat (50) step();
        check("ready_while_off", audio_ready, 1);
        check("held_kept", env_out, 33764);
        start();
        run_to(1023);
        check("reenable_no_underrun", underrun, 0);
        run_to(1025);
        check("reenable_hold", env_out, 33764);
        run_to(1026);
        check("reenable_pop", env_out, 30775);
        run_to(2048);
        check("reenable_underrun", underrun, 1);
`else
        // Linear ramp from 0 to 1024
        do_reset();
        mod_depth = 8'd255;
        push(16'sd0);
        push(16'sd1024);
        start();
        run_to(2050);
        check("interp_start", env_out, 32768);
        prev_env = env_out;
        flag = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (env_out < prev_env || env_out > prev_env + 16'd1) flag = 1'b0;
            prev_env = env_out;
        end
        check("interp_monotonic", flag, 1);
        check("interp_end", env_out, 33788);
`endif

        // Reset mid-operation discards queued samples
        do_reset();
        push(16'sd1000);
        push(16'sd2000);
        start();
        run_to(100);
        RST = 1'b1;
        step();
        check("midrst_ready", audio_ready, 0);
        check("midrst_env", env_out, 16'h8000);
        check("midrst_rf", rf_out, 0);
        do_reset();
        start();
        run_to(1024);
        check("midrst_discarded", underrun, 1);
        run_to(1026);
        check("midrst_env_idle", env_out, 32768);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
